conv2_sched: RTL and testbench



---
 rtl/conv2_sched.sv | 155 +++++++++++++++
 tb/tb_conv2_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/conv2_sched.sv
// rtl/conv2_sched.sv - conv2 layer sequencer: 3 out channels x 8x8 pixels, 5x5 kernel MAC walk
// Optional CONV2_SCHED_STALL_CNT_EN adds stall_cnt (WRITE cycles spent waiting on wr_ready).
module conv2_sched #(
  parameter int IMG_W   = 12,
  parameter int K       = 5,
  parameter int OUT_CH  = 3,
  parameter int MAC_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        mac_clr,
  output logic        mac_en,
  output logic [7:0]  in_addr,
  output logic [6:0]  w_addr,
  output logic        out_we,
  output logic [5:0]  out_addr,
  output logic [1:0]  out_ch
`ifdef CONV2_SCHED_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam logic [7:0] CH_MAX  = 8'(OUT_CH - 1);
  localparam logic [7:0] OW_MAX  = 8'(OUT_W - 1);
  localparam logic [7:0] K_MAX   = 8'(K - 1);
  localparam logic [7:0] LAT_MAX = 8'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, WRITE, DONE} state_t;

  state_t     state, state_n;
  logic [7:0] ch, oy, ox, ky, kx, lat;
  logic [7:0] ch_n, oy_n, ox_n, ky_n, kx_n, lat_n;
  logic       last_pix;

  assign last_pix = (ch == CH_MAX) && (oy == OW_MAX) && (ox == OW_MAX);

  always_comb begin
    state_n = state;
    ch_n    = ch;
    oy_n    = oy;
    ox_n    = ox;
    ky_n    = ky;
    kx_n    = kx;
    lat_n   = lat;
    case (state)
      IDLE: if (start) state_n = CLEAR;
      CLEAR: state_n = MAC;
      MAC: begin
        // On the final tap ky/kx are left at K-1 so addresses hold through DRAIN/WRITE.
        if (kx == K_MAX) begin
          if (ky == K_MAX) begin
            state_n = DRAIN;
            lat_n   = 8'd0;
          end else begin
            kx_n = 8'd0;
            ky_n = ky + 8'd1;
          end
        end else begin
          kx_n = kx + 8'd1;
        end
      end
      DRAIN: begin
        if (lat == LAT_MAX) state_n = WRITE;
        else                lat_n   = lat + 8'd1;
      end
      WRITE: begin
        if (wr_ready) begin
          ky_n  = 8'd0;
          kx_n  = 8'd0;
          lat_n = 8'd0;
          if (ox == OW_MAX) begin
            ox_n = 8'd0;
            if (oy == OW_MAX) begin
              oy_n = 8'd0;
              ch_n = (ch == CH_MAX) ? 8'd0 : ch + 8'd1;
            end else begin
              oy_n = oy + 8'd1;
            end
          end else begin
            ox_n = ox + 8'd1;
          end
          state_n = last_pix ? DONE : CLEAR;
        end
      end
      DONE: begin
        state_n = IDLE;
        ch_n    = 8'd0;
        oy_n    = 8'd0;
        ox_n    = 8'd0;
        ky_n    = 8'd0;
        kx_n    = 8'd0;
        lat_n   = 8'd0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ch       <= 8'd0;
      oy       <= 8'd0;
      ox       <= 8'd0;
      ky       <= 8'd0;
      kx       <= 8'd0;
      lat      <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mac_clr  <= 1'b0;
      mac_en   <= 1'b0;
      out_we   <= 1'b0;
      in_addr  <= 8'd0;
      w_addr   <= 7'd0;
      out_addr <= 6'd0;
      out_ch   <= 2'd0;
    end else begin
      state    <= state_n;
      ch       <= ch_n;
      oy       <= oy_n;
      ox       <= ox_n;
      ky       <= ky_n;
      kx       <= kx_n;
      lat      <= lat_n;
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
      mac_clr  <= (state_n == CLEAR);
      mac_en   <= (state_n == MAC);
      out_we   <= (state_n == WRITE);
      in_addr  <= 8'((32'(oy_n) + 32'(ky_n)) * 32'(IMG_W) + 32'(ox_n) + 32'(kx_n));
      w_addr   <= 7'(32'(ch_n) * 32'(K * K) + 32'(ky_n) * 32'(K) + 32'(kx_n));
      out_addr <= 6'(32'(oy_n) * 32'(OUT_W) + 32'(ox_n));
      out_ch   <= 2'(ch_n);
    end
  end

`ifdef CONV2_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (state == IDLE && start) begin
      stall_cnt <= 16'd0;
    end else if (state == WRITE && !wr_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv2_sched.sv
// tb/tb_conv2_sched.sv - directed bench for conv2_sched (checks stall_cnt when CONV2_SCHED_STALL_CNT_EN is set)
module tb_conv2_sched;

  logic       clk;
  logic       reset;
  logic       start;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic       mac_clr;
  logic       mac_en;
  logic [7:0] in_addr;
  logic [6:0] w_addr;
  logic       out_we;
  logic [5:0] out_addr;
  logic [1:0] out_ch;
`ifdef CONV2_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  conv2_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done),
    .mac_clr  (mac_clr),
    .mac_en   (mac_en),
    .in_addr  (in_addr),
    .w_addr   (w_addr),
    .out_we   (out_we),
    .out_addr (out_addr),
    .out_ch   (out_ch)
`ifdef CONV2_SCHED_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one layer from a start pulse; cycle 1 is the cycle right after the start edge.
  task automatic run_layer(input string tag, input bit hold, input int stall_n);
    int cyc, n_wr, done_cyc, done_cnt, clr_n, first_clear, second_clear, first_we;
    int we0_cycles, mac_idx, addr_err, excl_err, wr_err, busy_err, stab_err;
    int busy_after, tail, stall_left, stall_seen, p, exp_in, exp_w;
    int f_in[192], l_in[192], f_w[192], l_w[192];
    cyc = 0; n_wr = 0; done_cyc = 0; done_cnt = 0; clr_n = 0; first_clear = 0;
    second_clear = 0; first_we = 0; we0_cycles = 0; mac_idx = 0; addr_err = 0;
    excl_err = 0; wr_err = 0; busy_err = 0; stab_err = 0; busy_after = 1; tail = -1;
    stall_left = stall_n; stall_seen = -1;
    for (int i = 0; i < 192; i++) begin
      f_in[i] = -1; l_in[i] = -1; f_w[i] = -1; l_w[i] = -1;
    end
    wr_ready = 1'b1;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    cyc = 1;
    while (cyc <= 6000) begin
      if (int'(mac_clr) + int'(mac_en) + int'(out_we) > 1) excl_err++;
      if (done_cyc == 0 && busy !== 1'b1) busy_err++;
      if (mac_clr) begin
        clr_n++;
        if (clr_n == 1) first_clear = cyc;
        if (clr_n == 2) second_clear = cyc;
        mac_idx = 0;
      end
      if (mac_en && n_wr < 192 && mac_idx < 25) begin
        p = n_wr;
        exp_in = ((p % 64) / 8 + mac_idx / 5) * 12 + (p % 8) + mac_idx % 5;
        exp_w  = (p / 64) * 25 + mac_idx;
        if (int'(in_addr) != exp_in || int'(w_addr) != exp_w) addr_err++;
        if (mac_idx == 0) begin
          f_in[p] = int'(in_addr);
          f_w[p]  = int'(w_addr);
        end
        if (mac_idx == 24) begin
          l_in[p] = int'(in_addr);
          l_w[p]  = int'(w_addr);
        end
        mac_idx++;
      end
      if (out_we) begin
        if (first_we == 0) first_we = cyc;
        if (n_wr == 0) begin
          we0_cycles++;
          if (out_addr != 6'd0 || out_ch != 2'd0) stab_err++;
        end
        if (n_wr == 0 && stall_left > 0) begin
          wr_ready = 1'b0;
          stall_left--;
        end else begin
          wr_ready = 1'b1;
        end
        if (wr_ready) begin
          if (int'(out_addr) != n_wr % 64 || int'(out_ch) != n_wr / 64) wr_err++;
          n_wr++;
        end
      end else begin
        wr_ready = 1'b1;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) begin
        busy_after = int'(busy);
`ifdef CONV2_SCHED_STALL_CNT_EN
        stall_seen = int'(stall_cnt);
`endif
      end
      if (done_cyc != 0 && cyc == done_cyc + 2) begin
        tail = hold ? int'(mac_clr) : int'(busy);
        break;
      end
      step();
      cyc++;
    end
    wr_ready = 1'b1;
    check({tag, "/first_clear"}, first_clear, 1);
    check({tag, "/px0_in_first"}, f_in[0], 0);
    check({tag, "/px0_w_first"}, f_w[0], 0);
    check({tag, "/px0_in_last"}, l_in[0], 52);
    check({tag, "/px0_w_last"}, l_w[0], 24);
    check({tag, "/px1_in_first"}, f_in[1], 1);
    check({tag, "/px1_in_last"}, l_in[1], 53);
    check({tag, "/px191_w_first"}, f_w[191], 50);
    check({tag, "/px191_w_last"}, l_w[191], 74);
    check({tag, "/px191_in_last"}, l_in[191], 143);
    check({tag, "/first_we_cycle"}, first_we, 29);
    check({tag, "/first_we_len"}, we0_cycles, 1 + stall_n);
    check({tag, "/first_we_stable"}, stab_err, 0);
    check({tag, "/second_clear"}, second_clear, 30 + stall_n);
    check({tag, "/writes"}, n_wr, 192);
    check({tag, "/done_cycle"}, done_cyc, 5569 + stall_n);
    check({tag, "/done_pulses"}, done_cnt, 1);
    check({tag, "/addr_model"}, addr_err, 0);
    check({tag, "/write_seq"}, wr_err, 0);
    check({tag, "/exclusive"}, excl_err, 0);
    check({tag, "/busy_run"}, busy_err, 0);
    check({tag, "/busy_after_done"}, busy_after, 0);
    check({tag, "/tail"}, tail, hold ? 1 : 0);
`ifdef CONV2_SCHED_STALL_CNT_EN
    check({tag, "/stall_cnt"}, stall_seen, stall_n);
`endif
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    wr_ready = 1'b1;
    step();
    step();
    check("reset_outs", int'({busy, done, mac_clr, mac_en, out_we, in_addr, w_addr, out_addr, out_ch}), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_ctl", int'({busy, done, mac_clr, mac_en, out_we}), 0);
    end

    run_layer("base", 1'b0, 0);
    run_layer("stall", 1'b0, 5);
    run_layer("hold", 1'b1, 0);
    start = 1'b0;

    // The held start launched a new run; walk it to MAC tap 12 of ch=1 pixel 10.
    for (int c = 2; c <= 2160; c++) step();
    check("mid_mac_en", int'(mac_en), 1);
    check("mid_w_addr", int'(w_addr), 37);
    check("mid_in_addr", int'(in_addr), 40);
    reset = 1'b1;
    step();
    check("mid_reset_outs", int'({busy, done, mac_clr, mac_en, out_we, in_addr, w_addr, out_addr, out_ch}), 0);
    reset = 1'b0;
    step();
    check("mid_reset_idle", int'(busy), 0);

    run_layer("restart", 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
